// File: rtl/cache_rd_arbiter_pkg.sv
// Shared constants and types for the cache read-channel arbiter.
// AXI field encodings, transaction IDs and FSM state encoding.
package cache_rd_arbiter_pkg;

    localparam logic [2:0] AXI_SIZE_W     = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_ID_ICACHE  = 4'd0;
    localparam logic [3:0] AXI_ID_DCACHE  = 4'd1;

    typedef enum logic [1:0] {
        RA_IDLE = 2'd0,
        RA_AR   = 2'd1,
        RA_R    = 2'd2
    } ra_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: bit 0 is ICache, bit 1 is DCache.
// On a tie the requester that did not win last time is granted.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/cache_rd_arbiter.sv
// Shares one AXI read channel between ICache and DCache refills.
// One outstanding transaction; returned beats routed to the owner.
module cache_rd_arbiter
    import cache_rd_arbiter_pkg::*;
#(
    parameter int         LINE_WORDS = 4,
    parameter logic [3:0] ID_I       = AXI_ID_ICACHE,
    parameter logic [3:0] ID_D       = AXI_ID_DCACHE,
    localparam int        IW         = $clog2(LINE_WORDS)
) (
    input  logic          clk,
    input  logic          resetn,

    input  logic          i_rd_req,
    input  logic          i_rd_type,
    input  logic [31:0]   i_rd_addr,
    output logic          i_rd_rdy,
    output logic          i_ret_valid,
    output logic          i_ret_last,
    output logic [IW-1:0] i_ret_idx,
    output logic [31:0]   i_ret_data,

    input  logic          d_rd_req,
    input  logic          d_rd_type,
    input  logic [31:0]   d_rd_addr,
    output logic          d_rd_rdy,
    output logic          d_ret_valid,
    output logic          d_ret_last,
    output logic [IW-1:0] d_ret_idx,
    output logic [31:0]   d_ret_data,

    output logic [3:0]    arid,
    output logic [31:0]   araddr,
    output logic [7:0]    arlen,
    output logic [2:0]    arsize,
    output logic [1:0]    arburst,
    output logic          arvalid,
    input  logic          arready,

    input  logic [3:0]    rid,
    input  logic [31:0]   rdata,
    input  logic          rlast,
    input  logic          rvalid,
    output logic          rready
);

    ra_state_t     state;
    ra_state_t     state_d;
    owner_t        owner;
    owner_t        last_grant;
    owner_t        win;
    logic [IW-1:0] cnt;
    logic [1:0]    req;
    logic [1:0]    grant;
    logic          idle;
    logic          accept;
    logic          ar_hs;
    logic          hit;
    logic          done;

    assign req = {d_rd_req, i_rd_req};

    rr_arb2 u_arb (
        .req        (req),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign idle     = (state == RA_IDLE);
    assign i_rd_rdy = idle & grant[0];
    assign d_rd_rdy = idle & grant[1];
    assign accept   = i_rd_rdy | d_rd_rdy;
    assign win      = owner_t'(grant[1]);
    assign ar_hs    = (state == RA_AR) & arvalid & arready;

    // Beats tagged with another ID are still consumed, just not forwarded.
    assign hit  = (state == RA_R) & rready & rvalid & (rid == arid);
    assign done = hit & rlast;

    assign arsize  = AXI_SIZE_W;
    assign arburst = AXI_BURST_INCR;

    assign i_ret_valid = hit & (owner == OWN_I);
    assign i_ret_last  = rlast;
    assign i_ret_idx   = cnt;
    assign i_ret_data  = rdata;
    assign d_ret_valid = hit & (owner == OWN_D);
    assign d_ret_last  = rlast;
    assign d_ret_idx   = cnt;
    assign d_ret_data  = rdata;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= RA_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            RA_IDLE: if (accept) state_d = RA_AR;
            RA_AR:   if (ar_hs)  state_d = RA_R;
            RA_R:    if (done)   state_d = RA_IDLE;
            default:             state_d = RA_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            araddr     <= '0;
            arlen      <= '0;
            arid       <= '0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            cnt        <= '0;
            owner      <= OWN_I;
            last_grant <= OWN_I;
        end else begin
            if (accept) begin
                owner      <= win;
                last_grant <= win;
                arvalid    <= 1'b1;
                if (win == OWN_D) begin
                    araddr <= d_rd_addr;
                    arlen  <= d_rd_type ? 8'(LINE_WORDS - 1) : 8'd0;
                    arid   <= ID_D;
                end else begin
                    araddr <= i_rd_addr;
                    arlen  <= i_rd_type ? 8'(LINE_WORDS - 1) : 8'd0;
                    arid   <= ID_I;
                end
            end
            if (ar_hs) begin
                arvalid <= 1'b0;
                rready  <= 1'b1;
                cnt     <= '0;
            end
            if (hit) begin
                cnt <= cnt + IW'(1);
            end
            if (done) begin
                rready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// Directed bench for cache_rd_arbiter with hand-computed expectations.
// Inputs change 1 time unit after posedge; outputs sampled 1 unit later.
module tb_cache_rd_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        i_rd_req = 1'b0, i_rd_type = 1'b0;
    logic [31:0] i_rd_addr = '0;
    logic        i_rd_rdy, i_ret_valid, i_ret_last;
    logic [1:0]  i_ret_idx;
    logic [31:0] i_ret_data;
    logic        d_rd_req = 1'b0, d_rd_type = 1'b0;
    logic [31:0] d_rd_addr = '0;
    logic        d_rd_rdy, d_ret_valid, d_ret_last;
    logic [1:0]  d_ret_idx;
    logic [31:0] d_ret_data;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready = 1'b0;
    logic [3:0]  rid = '0;
    logic [31:0] rdata = '0;
    logic        rlast = 1'b0, rvalid = 1'b0, rready;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] exp_addr;
    logic [7:0]  exp_len;

    always #5 clk = ~clk;

    cache_rd_arbiter dut (
        .clk(clk), .resetn(resetn),
        .i_rd_req(i_rd_req), .i_rd_type(i_rd_type),
        .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
        .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last),
        .i_ret_idx(i_ret_idx), .i_ret_data(i_ret_data),
        .d_rd_req(d_rd_req), .d_rd_type(d_rd_type),
        .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
        .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last),
        .d_ret_idx(d_ret_idx), .d_ret_data(d_ret_data),
        .arid(arid), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    // Raise one side's request, expect it to win alone, then see AR.
    task automatic accept(input bit is_d, input bit typ,
                          input logic [31:0] addr);
        if (is_d) begin
            d_rd_req = 1'b1; d_rd_type = typ; d_rd_addr = addr;
        end else begin
            i_rd_req = 1'b1; i_rd_type = typ; i_rd_addr = addr;
        end
        #1;
        check("rdy_win", is_d ? d_rd_rdy : i_rd_rdy, 1);
        check("rdy_lose", is_d ? i_rd_rdy : d_rd_rdy, 0);
        tick();
        if (is_d) d_rd_req = 1'b0;
        else      i_rd_req = 1'b0;
        exp_addr = addr;
        exp_len  = typ ? 8'd3 : 8'd0;
        check("arvalid", arvalid, 1);
        check("araddr", araddr, exp_addr);
        check("arlen", arlen, exp_len);
        check("arid", arid, is_d ? 1 : 0);
    endtask

    task automatic ar_hs(input int stall);
        for (int k = 0; k < stall; k++) begin
            check("stall_arvalid", arvalid, 1);
            check("stall_araddr", araddr, exp_addr);
            check("stall_arlen", arlen, exp_len);
            check("stall_rdy", {i_rd_rdy, d_rd_rdy}, 0);
            tick();
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check("hs_arvalid", arvalid, 0);
        check("hs_rready", rready, 1);
    endtask

    task automatic beat(input logic [3:0] id, input logic [31:0] data,
                        input bit last, input bit is_d,
                        input bit exp_v, input logic [1:0] exp_idx);
        rvalid = 1'b1; rid = id; rdata = data; rlast = last;
        #1;
        check("beat_rready", rready, 1);
        check("own_valid", is_d ? d_ret_valid : i_ret_valid, exp_v);
        check("other_valid", is_d ? i_ret_valid : d_ret_valid, 0);
        check("beat_rdy", {i_rd_rdy, d_rd_rdy}, 0);
        if (exp_v) begin
            check("ret_idx", is_d ? d_ret_idx : i_ret_idx, exp_idx);
            check("ret_last", is_d ? d_ret_last : i_ret_last, last);
            check("ret_data", is_d ? d_ret_data : i_ret_data, data);
        end
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        if (exp_v && last) check("end_rready", rready, 0);
    endtask

    task automatic line(input bit is_d, input logic [31:0] base);
        for (int k = 0; k < 4; k++)
            beat(is_d ? 4'd1 : 4'd0, base + k, k == 3, is_d, 1, 2'(k));
    endtask

    initial begin
        do_reset();
        check("rst_arvalid", arvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_araddr", araddr, 0);
        check("rst_arlen", arlen, 0);
        check("rst_arid", arid, 0);
        check("rst_rdy", {i_rd_rdy, d_rd_rdy}, 0);
        check("arsize", arsize, 3'b010);
        check("arburst", arburst, 2'b01);

        // D-only line read with a 2-cycle AR stall
        accept(1, 1, 32'h1fc0_0010);
        ar_hs(2);
        line(1, 32'hd000_0000);

        // Ties: first after reset -> D, then I, then D again
        do_reset();
        i_rd_req = 1; i_rd_type = 1; i_rd_addr = 32'h1fc0_0100;
        d_rd_req = 1; d_rd_type = 1; d_rd_addr = 32'h0000_1000;
        #1;
        check("tie1_d", d_rd_rdy, 1);
        check("tie1_i", i_rd_rdy, 0);
        tick();
        d_rd_req = 0;
        check("tie1_arid", arid, 1);
        check("tie1_addr", araddr, 32'h0000_1000);
        exp_addr = 32'h0000_1000; exp_len = 8'd3;
        ar_hs(0);
        line(1, 32'h1111_0000);
        check("tie2_i", i_rd_rdy, 1);
        tick();
        i_rd_req = 0;
        check("tie2_arid", arid, 0);
        check("tie2_addr", araddr, 32'h1fc0_0100);
        exp_addr = 32'h1fc0_0100;
        ar_hs(0);
        line(0, 32'h2222_0000);
        i_rd_req = 1;
        d_rd_req = 1; d_rd_type = 0; d_rd_addr = 32'hbfaf_8000;
        #1;
        check("tie3_d", d_rd_rdy, 1);
        check("tie3_i", i_rd_rdy, 0);
        tick();
        d_rd_req = 0; i_rd_req = 0;
        check("single_arlen", arlen, 0);
        check("single_addr", araddr, 32'hbfaf_8000);
        exp_addr = 32'hbfaf_8000; exp_len = 8'd0;
        ar_hs(0);
        beat(4'd1, 32'h5555_aaaa, 1, 1, 1, 2'd0);

        // Foreign-ID beat is dropped without advancing the index
        accept(1, 1, 32'h0000_2000);
        ar_hs(0);
        beat(4'd1, 32'h3000_0000, 0, 1, 1, 2'd0);
        beat(4'd0, 32'hdead_beef, 0, 1, 0, 2'd0);
        beat(4'd1, 32'h3000_0001, 0, 1, 1, 2'd1);
        beat(4'd1, 32'h3000_0002, 0, 1, 1, 2'd2);
        beat(4'd1, 32'h3000_0003, 1, 1, 1, 2'd3);

        // Long AR stall with the other side requesting
        accept(1, 1, 32'h0000_3000);
        i_rd_req = 1; i_rd_type = 1; i_rd_addr = 32'h0000_4000;
        ar_hs(10);
        i_rd_req = 0;
        line(1, 32'h4444_0000);

        // Reset in the middle of the R phase
        accept(0, 1, 32'h1fc0_0200);
        ar_hs(0);
        beat(4'd0, 32'h6000_0000, 0, 0, 1, 2'd0);
        beat(4'd0, 32'h6000_0001, 0, 0, 1, 2'd1);
        resetn = 0;
        tick();
        check("mid_rready", rready, 0);
        check("mid_arvalid", arvalid, 0);
        check("mid_araddr", araddr, 0);
        resetn = 1;
        accept(0, 1, 32'h1fc0_0300);
        ar_hs(0);
        line(0, 32'h7777_0000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
